// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding and default 24 MHz timing for the PLL reset sequencer
package pll_seq_pkg;
  typedef enum logic [2:0] {HOLD, WAIT_LOCK, STABILIZE, RUN, FAIL} state_t;
  localparam int DEF_RST_HOLD_CYCLES     = 24;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 24000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 2400;
  localparam int DEF_MAX_ATTEMPTS        = 3;
  localparam int DEF_CNT_W               = 16;
  typedef struct packed {
    logic pll_reset;
    logic sys_rst;
    logic ready;
    logic fail;
    logic lock_lost;
  } outs_t;
  localparam outs_t OUTS_RESET = '{pll_reset: 1'b1, sys_rst: 1'b1, ready: 1'b0, fail: 1'b0, lock_lost: 1'b0};
endpackage

// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: PLL control/status and downstream reset signals
interface pll_reset_sequencer_if;
  logic       pll_extlock;
  logic       relock_req;
  logic       pll_reset;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [3:0] attempt_cnt;
  modport master (input pll_extlock, relock_req, output pll_reset, sys_rst, ready, fail, lock_lost, attempt_cnt);
  modport slave (output pll_extlock, relock_req, input pll_reset, sys_rst, ready, fail, lock_lost, attempt_cnt);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: generic one-bit two-flop synchronizer
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (rst) {m, q} <= 2'b00;
    else {m, q} <= {d, m};
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds PLL in reset, qualifies lock, releases system reset, retries on timeout
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_ATTEMPTS        = DEF_MAX_ATTEMPTS,
  parameter int CNT_W               = DEF_CNT_W
) (
  input logic refclk,
  input logic reset,
  pll_reset_sequencer_if.master bus
);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       att, att_n;
  outs_t            o, o_n;
  logic             lock_s;

  sync_2ff u_sync (.clk(refclk), .rst(reset), .d(bus.pll_extlock), .q(lock_s));

  always_ff @(posedge refclk)
    if (reset) begin
      state <= HOLD;
      cnt   <= '0;
      att   <= '0;
      o     <= OUTS_RESET;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      att   <= att_n;
      o     <= o_n;
    end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    att_n   = att;
    case (state)
      HOLD:
        if (cnt == CNT_W'(RST_HOLD_CYCLES - 1)) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end
      WAIT_LOCK:
        if (lock_s) begin
          state_n = STABILIZE;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          att_n   = att + 4'd1;
          state_n = (att_n == 4'(MAX_ATTEMPTS)) ? FAIL : HOLD;
          cnt_n   = '0;
        end
      STABILIZE:
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_n = RUN;
          cnt_n   = '0;
          att_n   = '0;
        end
      RUN: begin
        cnt_n   = '0;
        att_n   = '0;
        state_n = (!lock_s || bus.relock_req) ? HOLD : RUN;
      end
      FAIL: begin
        cnt_n   = '0;
        state_n = bus.relock_req ? HOLD : FAIL;
        att_n   = bus.relock_req ? 4'd0 : att;
      end
      default: begin
        state_n = HOLD;
        cnt_n   = '0;
      end
    endcase
  end

  // outputs are decoded from the state being entered so they line up with it
  always_comb begin
    o_n.pll_reset = (state_n == HOLD) || (state_n == FAIL);
    o_n.sys_rst   = state_n != RUN;
    o_n.ready     = state_n == RUN;
    o_n.fail      = state_n == FAIL;
    o_n.lock_lost = (state == RUN) && !lock_s;
  end

  assign bus.pll_reset   = o.pll_reset;
  assign bus.sys_rst     = o.sys_rst;
  assign bus.ready       = o.ready;
  assign bus.fail        = o.fail;
  assign bus.lock_lost   = o.lock_lost;
  assign bus.attempt_cnt = att;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: table-driven directed checks of the PLL reset sequencer
module tb_pll_reset_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pll_reset_sequencer_if bus();
  pll_reset_sequencer #(
    .RST_HOLD_CYCLES(4), .LOCK_TIMEOUT_CYCLES(20), .LOCK_STABLE_CYCLES(8), .MAX_ATTEMPTS(2), .CNT_W(16)
  ) dut (.refclk(clk), .reset(rst), .bus(bus));

  typedef struct {
    int         scen;
    int         cyc;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;
  int ll_seen;

  function automatic logic [8:0] outs();
    return {bus.pll_reset, bus.sys_rst, bus.ready, bus.fail, bus.lock_lost, bus.attempt_cnt};
  endfunction

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, c, act, exp);
    end
  endtask

  function automatic logic lock_in(input int s, input int c);
    case (s)
      0: return c >= 6;
      2: return c >= 6 && !(c >= 12 && c <= 14);
      3, 4: return (c >= 6 && c < 20) || c >= 30;
      5: return c >= 50;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic relock_in(input int s, input int c);
    return (s == 4 && (c == 12 || c == 22)) || (s == 5 && c == 52);
  endfunction

  task automatic add(input int s, input int c, input logic [8:0] e);
    vec_t v;
    v.scen = s;
    v.cyc  = c;
    v.exp  = e;
    tbl.push_back(v);
  endtask

  task automatic start();
    rst = 1'b1;
    bus.pll_extlock = 1'b0;
    bus.relock_req  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run(input int s, input int n);
    start();
    ll_seen = 0;
    for (int c = 0; c <= n; c++) begin
      foreach (tbl[i])
        if (tbl[i].scen == s && tbl[i].cyc == c) chk($sformatf("scen%0d", s), c, 32'(outs()), 32'(tbl[i].exp));
      if (bus.lock_lost) ll_seen++;
      bus.pll_extlock = lock_in(s, c);
      bus.relock_req  = relock_in(s, c);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.pll_extlock = 1'b0;
    bus.relock_req  = 1'b0;
    // bits: pll_reset sys_rst ready fail lock_lost | attempt_cnt
    add(0, 0, 9'b11000_0000); add(0, 3, 9'b11000_0000); add(0, 4, 9'b01000_0000);
    add(0, 16, 9'b01000_0000); add(0, 17, 9'b00100_0000); add(0, 25, 9'b00100_0000);
    add(1, 0, 9'b11000_0000); add(1, 3, 9'b11000_0000); add(1, 4, 9'b01000_0000);
    add(1, 23, 9'b01000_0000); add(1, 24, 9'b11000_0001); add(1, 27, 9'b11000_0001);
    add(1, 28, 9'b01000_0001); add(1, 47, 9'b01000_0001); add(1, 48, 9'b11010_0010);
    add(1, 60, 9'b11010_0010);
    add(2, 9, 9'b01000_0000); add(2, 17, 9'b01000_0000); add(2, 25, 9'b01000_0000);
    add(2, 26, 9'b00100_0000);
    add(3, 17, 9'b00100_0000); add(3, 22, 9'b00100_0000); add(3, 23, 9'b11001_0000);
    add(3, 24, 9'b11000_0000); add(3, 26, 9'b11000_0000); add(3, 27, 9'b01000_0000);
    add(3, 40, 9'b01000_0000); add(3, 41, 9'b00100_0000);
    add(4, 17, 9'b00100_0000); add(4, 23, 9'b11001_0000); add(4, 24, 9'b11000_0000);
    add(4, 27, 9'b01000_0000); add(4, 41, 9'b00100_0000);
    add(5, 48, 9'b11010_0010); add(5, 51, 9'b11010_0010); add(5, 53, 9'b11000_0000);
    add(5, 56, 9'b11000_0000); add(5, 57, 9'b01000_0000); add(5, 65, 9'b01000_0000);
    add(5, 66, 9'b00100_0000);

    run(0, 30);
    chk("nominal_lock_lost_count", 30, 32'(ll_seen), 32'd0);
    run(1, 62);
    run(2, 30);
    run(3, 45);
    chk("loss_lock_lost_count", 45, 32'(ll_seen), 32'd1);
    run(4, 45);
    chk("simul_lock_lost_count", 45, 32'(ll_seen), 32'd1);
    run(5, 70);

    start();
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_wait_lock", 30, 32'(outs()), 32'(9'b01000_0001));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset_values", 31, 32'(outs()), 32'(9'b11000_0000));
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_hold", 3, 32'(outs()), 32'(9'b11000_0000));
    @(posedge clk);
    #1;
    chk("post_reset_release", 4, 32'(outs()), 32'(9'b01000_0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
